bsg_manycore_axi_burst_master: RTL and testbench

- AXI4 initiator that converts simple valid/ready burst commands into full AXI4 INCR bursts on the AW/W/B and AR/R channels.
- Sits between a manycore-side memory client (cache DMA, test driver) and an AXI memory responder.
- Keeps exactly one transaction outstanding at a time: a write burst or a read burst.
- Checks responder protocol and latches a sticky error flag on any violation.

---
 rtl/bsg_manycore_axi_burst_master.sv | 170 +++++++++++++++++
 tb/tb_bsg_manycore_axi_burst_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_axi_burst_master.sv
// AXI4 burst initiator: one outstanding fixed-length INCR burst (read or write) at a time,
// with beat-stream pass-through and a sticky responder protocol error flag.
module bsg_manycore_axi_burst_master #(
  parameter int axi_id_width_p   = 6,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_burst_len_p  = 4,
  parameter int axi_id_p         = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cmd_v_i,
  input  logic                          cmd_write_i,
  input  logic [axi_addr_width_p-1:0]   cmd_addr_i,
  output logic                          cmd_ready_o,
  input  logic                          wdata_v_i,
  input  logic [axi_data_width_p-1:0]   wdata_i,
  input  logic [axi_data_width_p/8-1:0] wstrb_i,
  output logic                          wdata_ready_o,
  output logic                          rdata_v_o,
  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic                          rdata_last_o,
  input  logic                          rdata_ready_i,
  output logic                          wr_done_o,
  output logic                          err_o,
  output logic [axi_id_width_p-1:0]     axi_awid_o,
  output logic [axi_addr_width_p-1:0]   axi_awaddr_o,
  output logic [7:0]                    axi_awlen_o,
  output logic [2:0]                    axi_awsize_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,
  output logic [axi_data_width_p-1:0]   axi_wdata_o,
  output logic [axi_data_width_p/8-1:0] axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,
  input  logic [axi_id_width_p-1:0]     axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o,
  output logic [axi_id_width_p-1:0]     axi_arid_o,
  output logic [axi_addr_width_p-1:0]   axi_araddr_o,
  output logic [7:0]                    axi_arlen_o,
  output logic [2:0]                    axi_arsize_o,
  output logic [1:0]                    axi_arburst_o,
  output logic                          axi_arvalid_o,
  input  logic                          axi_arready_i,
  input  logic [axi_id_width_p-1:0]     axi_rid_i,
  input  logic [axi_data_width_p-1:0]   axi_rdata_i,
  input  logic [1:0]                    axi_rresp_i,
  input  logic                          axi_rlast_i,
  input  logic                          axi_rvalid_i,
  output logic                          axi_rready_o
);

  localparam int axi_strb_width_lp = axi_data_width_p >> 3;
  localparam int lg_beat_bytes_lp  = $clog2(axi_strb_width_lp);
  localparam int cnt_w_lp          = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
  localparam logic [cnt_w_lp-1:0]       last_cnt_lp = cnt_w_lp'(axi_burst_len_p - 1);
  localparam logic [axi_id_width_p-1:0] id_lp       = axi_id_width_p'(axi_id_p);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                      state_r, state_n;
  logic [cnt_w_lp-1:0]         cnt_r;
  logic [axi_addr_width_p-1:0] addr_r;
  logic                        err_r, err_set;
  logic                        is_last, cmd_hs, w_hs, r_hs;

  assign is_last = (cnt_r == last_cnt_lp);
  assign cmd_hs  = cmd_ready_o & cmd_v_i;
  assign w_hs    = (state_r == WR_DATA) & wdata_v_i & axi_wready_i;
  assign r_hs    = (state_r == RD_DATA) & axi_rvalid_i & rdata_ready_i;

  // Address-channel fields are constant except for the latched address.
  assign axi_awid_o    = id_lp;
  assign axi_awaddr_o  = addr_r;
  assign axi_awlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_awsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_awburst_o = 2'b01;
  assign axi_arid_o    = id_lp;
  assign axi_araddr_o  = addr_r;
  assign axi_arlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_arsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_arburst_o = 2'b01;

  assign axi_wdata_o   = wdata_i;
  assign axi_wstrb_o   = wstrb_i;
  assign axi_wlast_o   = is_last;
  assign rdata_o       = axi_rdata_i;
  assign rdata_last_o  = is_last;
  assign err_o         = err_r;

  always_comb begin
    state_n       = state_r;
    cmd_ready_o   = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    wdata_ready_o = 1'b0;
    axi_bready_o  = 1'b0;
    wr_done_o     = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    rdata_v_o     = 1'b0;
    case (state_r)
      IDLE: begin
        // Gated by reset so nothing handshakes while reset is held.
        cmd_ready_o = reset_n_i;
        if (reset_n_i && cmd_v_i) state_n = cmd_write_i ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) state_n = WR_DATA;
      end
      WR_DATA: begin
        axi_wvalid_o  = wdata_v_i;
        wdata_ready_o = axi_wready_i;
        if (w_hs && is_last) state_n = WR_RESP;
      end
      WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          wr_done_o = 1'b1;
          state_n   = IDLE;
        end
      end
      RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_n = RD_DATA;
      end
      RD_DATA: begin
        rdata_v_o    = axi_rvalid_i;
        axi_rready_o = rdata_ready_i;
        // Burst end is counted locally; the responder's rlast is only checked.
        if (r_hs && is_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    err_set = 1'b0;
    if (axi_bvalid_i && state_r != WR_RESP) err_set = 1'b1;
    if (axi_rvalid_i && state_r != RD_DATA) err_set = 1'b1;
    if (state_r == WR_RESP && axi_bvalid_i && (axi_bresp_i != 2'b00 || axi_bid_i != id_lp))
      err_set = 1'b1;
    if (r_hs && (axi_rlast_i != is_last || axi_rresp_i != 2'b00 || axi_rid_i != id_lp))
      err_set = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      err_r   <= err_r | err_set;
      if (cmd_hs) begin
        addr_r <= {cmd_addr_i[axi_addr_width_p-1:lg_beat_bytes_lp], {lg_beat_bytes_lp{1'b0}}};
        cnt_r  <= '0;
      end else if (w_hs || r_hs) begin
        cnt_r <= is_last ? '0 : cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bsg_manycore_axi_burst_master.sv
// Scoreboard bench: stimulus tasks push expected AW/W/AR/R traffic, a negedge monitor pops and compares.
module tb_bsg_manycore_axi_burst_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_v = 0, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic        cmd_ready;
  logic        wdata_v = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  wstrb = 0;
  logic        wdata_ready;
  logic        rdata_v, rdata_last, wr_done, err;
  logic [63:0] rdata;
  logic        rdata_ready = 0;
  logic [5:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        awready = 1, wready = 1, arready = 1;
  logic [5:0]  bid = 0, rid = 0;
  logic [1:0]  bresp = 0, rresp = 0;
  logic        bvalid = 0, rvalid = 0, rlast = 0;
  logic [63:0] axi_rdata = 0;

  always #5 clk = ~clk;

  bsg_manycore_axi_burst_master dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_ready_o(cmd_ready),
    .wdata_v_i(wdata_v), .wdata_i(wdata), .wstrb_i(wstrb), .wdata_ready_o(wdata_ready),
    .rdata_v_o(rdata_v), .rdata_o(rdata), .rdata_last_o(rdata_last), .rdata_ready_i(rdata_ready),
    .wr_done_o(wr_done), .err_o(err),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(wlast), .axi_wvalid_o(wvalid),
    .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(axi_rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last;} w_t;
  typedef struct packed {logic [63:0] data; logic last;} r_t;

  logic [31:0] aw_q[$], ar_q[$];
  w_t          w_q[$];
  r_t          r_q[$];
  int          errors = 0, checks = 0, done_seen = 0, done_exp = 0;
  logic        aw_ok = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake with empty scoreboard", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake is compared against the scoreboard.
  always @(negedge clk) begin : mon
    logic [31:0] a;
    w_t w;
    r_t r;
    if (!reset_n) aw_ok = 0;
    else begin
      if (awvalid && awready) begin
        if (aw_q.size() == 0) unexpected("aw");
        else begin
          a = aw_q.pop_front();
          check("awaddr", awaddr, a);
          check("awlen", awlen, 3);
          check("awsize", awsize, 3);
          check("awburst", awburst, 1);
          check("awid", awid, 0);
        end
        aw_ok = 1;
      end
      if (wvalid && wready) begin
        check("w_after_aw", aw_ok, 1);
        if (w_q.size() == 0) unexpected("w");
        else begin
          w = w_q.pop_front();
          check("wdata", axi_wdata, w.data);
          check("wstrb", axi_wstrb, w.strb);
          check("wlast", wlast, w.last);
        end
        if (wlast) aw_ok = 0;
      end
      if (arvalid && arready) begin
        if (ar_q.size() == 0) unexpected("ar");
        else begin
          a = ar_q.pop_front();
          check("araddr", araddr, a);
          check("arlen", arlen, 3);
          check("arsize", arsize, 3);
          check("arburst", arburst, 1);
        end
      end
      if (rdata_v && rdata_ready) begin
        if (r_q.size() == 0) unexpected("r");
        else begin
          r = r_q.pop_front();
          check("rdata", rdata, r.data);
          check("rdata_last", rdata_last, r.last);
        end
      end
      if (wr_done) done_seen++;
    end
  end

  task automatic send_cmd(input logic wr, input logic [31:0] addr);
    int n = 0;
    cmd_v = 1; cmd_write = wr; cmd_addr = addr;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (n >= 20) check("cmd_timeout", n, 0);
    tick();
    cmd_v = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] d[4], input logic [7:0] strb,
                          input logic [1:0] resp, input int nbeats);
    w_t w;
    int n;
    aw_q.push_back(addr & ~32'h7);
    for (int i = 0; i < nbeats; i++) begin
      w.data = d[i]; w.strb = strb; w.last = (i == 3);
      w_q.push_back(w);
    end
    send_cmd(1, addr);
    wdata_v = 1; wstrb = strb;
    for (int i = 0; i < nbeats; i++) begin
      wdata = d[i];
      n = 0;
      while (!wdata_ready && n < 20) begin tick(); n++; end
      if (n >= 20) check("w_timeout", n, 0);
      tick();
    end
    wdata_v = 0;
    if (nbeats == 4) begin
      done_exp++;
      bvalid = 1; bresp = resp; bid = 0;
      n = 0;
      while (!bready && n < 20) begin tick(); n++; end
      if (n >= 20) check("b_timeout", n, 0);
      tick();
      bvalid = 0; bresp = 0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [63:0] d[4], input int bad, input logic toggle);
    r_t r;
    int n = 0, i = 0;
    logic ph = 0, hs;
    ar_q.push_back(addr & ~32'h7);
    for (int k = 0; k < 4; k++) begin
      r.data = d[k]; r.last = (k == 3);
      r_q.push_back(r);
    end
    send_cmd(0, addr);
    while (!(arvalid && arready) && n < 20) begin tick(); n++; end
    if (n >= 20) check("ar_timeout", n, 0);
    tick();
    n = 0;
    while (i < 4 && n < 60) begin
      rvalid = 1; axi_rdata = d[i]; rid = 0; rresp = 0;
      rlast = (bad >= 0) ? (i == bad) : (i == 3);
      rdata_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      hs = rready;
      tick();
      if (hs) i++;
      n++;
    end
    if (n >= 60) check("r_timeout", n, 0);
    rvalid = 0; rlast = 0; rdata_ready = 0;
  endtask

  logic [63:0] dw[4], dr[4], dr2[4];

  initial begin
    dw  = '{64'h11, 64'h22, 64'h33, 64'h44};
    dr  = '{64'hA1A1_0000_0000_0001, 64'hB2B2_0000_0000_0002, 64'hC3C3_0000_0000_0003, 64'hD4D4_0000_0000_0004};
    dr2 = '{64'h5555, 64'h6666, 64'h7777, 64'h8888};

    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_err", err, 0);
    tick();
    reset_n = 1;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_valids", {awvalid, wvalid, arvalid, bready, rready, rdata_v, wdata_ready, wr_done}, 0);
    check("idle_err", err, 0);

    do_write(32'h1003, dw, 8'hFF, 2'b00, 4);
    check("wr1_done_cnt", done_seen, done_exp);
    check("wr1_idle", cmd_ready, 1);
    check("wr1_err", err, 0);

    do_read(32'h2000, dr, -1, 1'b1);
    check("rd1_r_q_empty", r_q.size(), 0);
    check("rd1_idle", cmd_ready, 1);
    check("rd1_err", err, 0);

    do_write(32'h3008, dw, 8'h3C, 2'b10, 4);
    check("wr2_done_cnt", done_seen, done_exp);
    check("wr2_bresp_err", err, 1);

    reset_n = 0;
    #1;
    check("rst2_err_clear", err, 0);
    tick();
    reset_n = 1;
    tick();

    do_read(32'h4000, dr2, 1, 1'b0);
    check("rd2_rlast_err", err, 1);
    check("rd2_r_q_empty", r_q.size(), 0);
    check("rd2_idle", cmd_ready, 1);
    repeat (3) tick();
    check("rd2_err_sticky", err, 1);

    do_write(32'h5000, dw, 8'h0F, 2'b00, 2);
    wdata_v = 1;
    #1;
    check("mid_wvalid_pre", wvalid, 1);
    #1;
    reset_n = 0;
    #1;
    check("mid_rst_valids", {awvalid, wvalid, wdata_ready, bready, cmd_ready, wr_done}, 0);
    wdata_v = 0;
    tick();
    reset_n = 1;
    tick();
    check("mid_rst_idle", cmd_ready, 1);
    check("mid_rst_err", err, 0);
    check("mid_rst_w_q_empty", w_q.size(), 0);

    do_read(32'h6004, dr, -1, 1'b0);
    check("rd3_err", err, 0);
    check("rd3_idle", cmd_ready, 1);
    repeat (2) tick();
    check("final_done_cnt", done_seen, done_exp);
    check("final_q_empty", aw_q.size() + ar_q.size() + w_q.size() + r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
